// File: rtl/hamming_batch_ctrl.sv
// Batch controller streaming Hamming-coded words through one shared decoder,
// with an output FIFO, a saturating per-batch error count and a done pulse.

module hamming_ip #(
   parameter int IP_BIT = 11
) (
   input  logic [IP_BIT+3:0] in_code,
   output logic [IP_BIT-1:0] out_data
);
   localparam int CW    = IP_BIT + 4;
   localparam int SYN_W = $clog2(CW + 1);

   logic [SYN_W-1:0] syn;
   logic [CW-1:0]    fixed;
   int               k;

   // Position p (1-based) lives at bit CW-p; data bits are the non-power-of-two positions.
   always_comb begin
      syn      = '0;
      fixed    = in_code;
      out_data = '0;
      k        = IP_BIT - 1;
      for (int p = 1; p <= CW; p++) begin
         if (in_code[CW-p]) syn = syn ^ p[SYN_W-1:0];
      end
      for (int p = 1; p <= CW; p++) begin
         if (syn == SYN_W'(p)) fixed[CW-p] = ~fixed[CW-p];
      end
      for (int p = 1; p <= CW; p++) begin
         if ((p & (p - 1)) != 0) begin
            out_data[k] = fixed[CW-p];
            k           = k - 1;
         end
      end
   end
endmodule

module hamming_batch_ctrl #(
   parameter int IP_BIT = 11,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_last,
   input  logic [IP_BIT+3:0] in_code,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IP_BIT-1:0] out_data,
   output logic              out_err,
   output logic              out_last,
   output logic              done,
   output logic [CNT_W-1:0]  err_cnt
);
   localparam int CW    = IP_BIT + 4;
   localparam int SYN_W = $clog2(CW + 1);
   localparam int AW    = $clog2(DEPTH);
   localparam int FW    = AW + 1;
   localparam logic [FW-1:0] FULL = FW'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state_q, state_d;
   logic [SYN_W-1:0]  in_syn;
   logic              in_err;
   logic              accept, pop, push, s1_moves;

   logic              vld_p1;
   logic [CW-1:0]     code_p1;
   logic              last_p1;
   logic [SYN_W-1:0]  syn_p1;
   logic [IP_BIT-1:0] ip_data;

   logic [IP_BIT-1:0] mem_data [DEPTH];
   logic              mem_err  [DEPTH];
   logic              mem_last [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [FW-1:0]     fifo_cnt;

   function automatic logic [SYN_W-1:0] syndrome(input logic [CW-1:0] code);
      logic [SYN_W-1:0] s;
      s = '0;
      for (int p = 1; p <= CW; p++) begin
         if (code[CW-p]) s = s ^ p[SYN_W-1:0];
      end
      return s;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   assign in_syn    = syndrome(in_code);
   assign in_err    = (in_syn != '0);
   assign out_valid = (fifo_cnt != '0);
   assign pop       = out_valid && out_ready;
   // A full FIFO still accepts S1 when the head leaves on the same edge.
   assign s1_moves  = vld_p1 && ((fifo_cnt != FULL) || pop);
   assign push      = s1_moves;
   assign in_ready  = rst_n && (state_q == IDLE || state_q == RUN) && (!vld_p1 || s1_moves);
   assign accept    = in_valid && in_ready;

   // ---- S1: accepted word, last flag and syndrome ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        vld_p1 <= 1'b0;
      else if (accept)   vld_p1 <= 1'b1;
      else if (s1_moves) vld_p1 <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         code_p1 <= in_code;
         last_p1 <= in_last;
         syn_p1  <= in_syn;
      end
   end

   hamming_ip #(.IP_BIT(IP_BIT)) u_ip (
      .in_code  (code_p1),
      .out_data (ip_data)
   );

   // ---- FIFO: corrected data, err and last flags ----
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= ip_data;
         mem_err[wr_ptr]  <= (syn_p1 != '0);
         mem_last[wr_ptr] <= last_p1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   assign out_data = out_valid ? mem_data[rd_ptr] : '0;
   assign out_err  = out_valid ? mem_err[rd_ptr]  : 1'b0;
   assign out_last = out_valid ? mem_last[rd_ptr] : 1'b0;

   // ---- Batch framing FSM and error counter ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = in_last ? DRAIN : RUN;
         RUN:     if (accept && in_last) state_d = DRAIN;
         DRAIN:   if (pop && out_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign done = (state_q == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          err_cnt <= '0;
      else if (accept && state_q == IDLE)  err_cnt <= in_err ? CNT_W'(1) : '0;
      else if (accept && in_err)           err_cnt <= sat_inc(err_cnt);
   end
endmodule

// File: tb/tb_hamming_batch_ctrl.sv
// Directed bench for hamming_batch_ctrl; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.

module tb_hamming_batch_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_last, out_ready;
   logic [14:0] in_code;

   logic        in_ready, out_valid, out_err, out_last, done;
   logic [10:0] out_data;
   logic [7:0]  err_cnt;

   logic        in_ready2, out_valid2, out_err2, out_last2, done2;
   logic [10:0] out_data2;
   logic [1:0]  err_cnt2;

   int checks   = 0;
   int failures = 0;

   logic [14:0] vc [16];
   logic [10:0] vd [16];
   logic        ve [16];

   always #5 clk = ~clk;

   hamming_batch_ctrl #(.IP_BIT(11), .DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
      .in_code(in_code), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
      .out_last(out_last), .done(done), .err_cnt(err_cnt)
   );

   hamming_batch_ctrl #(.IP_BIT(11), .DEPTH(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
      .in_code(in_code), .in_ready(in_ready2), .out_valid(out_valid2),
      .out_ready(out_ready), .out_data(out_data2), .out_err(out_err2),
      .out_last(out_last2), .done(done2), .err_cnt(err_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic setv(input int i, input logic [14:0] c, input logic [10:0] d, input logic e);
      vc[i] = c;
      vd[i] = d;
      ve[i] = e;
   endtask

   // mode 0: out_ready=1, mode 1: random, mode 2: low for 'hold' cycles then high
   task automatic run_batch(input int n, input int mode, input int hold,
                            input int exp_cnt, input int exp_cnt2);
      int sent = 0, popped = 0, cyc = 0, done_cnt = 0;
      int first_acc = -1, last_acc = -1, first_vld = -1, last_pop = -1, done_cyc = 0;
      logic acc, pp;
      while (cyc < 400) begin
         if (popped == n && done_cnt > 0 && cyc > done_cyc + 2) break;
         in_valid  = (sent < n);
         in_code   = (sent < n) ? vc[sent] : 15'h0;
         in_last   = (sent == n - 1);
         out_ready = (mode == 0) ? 1'b1 :
                     (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc >= hold);
         #3;
         acc = in_valid && in_ready;
         pp  = out_valid && out_ready;
         if (mode == 2 && cyc == hold - 1) begin
            chk("bp_accepted", sent, 5);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
         end
         if (out_valid && first_vld < 0) first_vld = cyc;
         if (pp) begin
            if (popped < n) begin
               chk("out_data", out_data, vd[popped]);
               chk("out_err", out_err, ve[popped]);
               chk("out_last", out_last, (popped == n - 1));
               chk("out_data2", out_data2, vd[popped]);
               chk("out_err2", out_err2, ve[popped]);
               chk("out_last2", out_last2, (popped == n - 1));
            end else begin
               chk("extra_pop", 1, 0);
            end
            popped++;
            last_pop = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_delay", cyc - last_pop, 1);
            chk("err_cnt", err_cnt, exp_cnt);
            chk("err_cnt2", err_cnt2, exp_cnt2);
            chk("done2", done2, 1);
         end
         if (acc) begin
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      chk("batch_complete", (popped == n && done_cnt > 0), 1);
      chk("done_once", done_cnt, 1);
      if (mode == 0) begin
         chk("latency", first_vld - first_acc, 2);
         chk("throughput", last_acc - first_acc, n - 1);
      end
      #3;
      chk("cnt_hold", err_cnt, exp_cnt);
      chk("idle_ready", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_code = '0;
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_done", done, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_in_ready2", in_ready2, 0);
      chk("rst_out_valid2", out_valid2, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #2;
      chk("post_rst_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // single clean word
      setv(0, 15'h0000, 11'h000, 1'b0);
      run_batch(1, 0, 0, 0, 0);

      // data-position and parity-position errors on the zero codeword
      setv(0, 15'h1000, 11'h000, 1'b1);
      setv(1, 15'h4000, 11'h000, 1'b1);
      run_batch(2, 0, 0, 2, 2);

      // backpressure: 4 in FIFO + 1 in S1 before stall
      setv(0, 15'h7000, 11'h400, 1'b0);
      setv(1, 15'h7FFF, 11'h7FF, 1'b0);
      setv(2, 15'h6881, 11'h001, 1'b0);
      setv(3, 15'h6880, 11'h001, 1'b1);
      setv(4, 15'h7F7F, 11'h7FF, 1'b1);
      setv(5, 15'h7040, 11'h400, 1'b1);
      run_batch(6, 2, 8, 3, 3);

      // 10 words, 3 errors, random downstream ready
      setv(0, 15'h0000, 11'h000, 1'b0);
      setv(1, 15'h7000, 11'h400, 1'b0);
      setv(2, 15'h7FFF, 11'h7FF, 1'b0);
      setv(3, 15'h1000, 11'h000, 1'b1);
      setv(4, 15'h6881, 11'h001, 1'b0);
      setv(5, 15'h0000, 11'h000, 1'b0);
      setv(6, 15'h7F7F, 11'h7FF, 1'b1);
      setv(7, 15'h7000, 11'h400, 1'b0);
      setv(8, 15'h7040, 11'h400, 1'b1);
      setv(9, 15'h7FFF, 11'h7FF, 1'b0);
      run_batch(10, 1, 0, 3, 3);

      // next batch restarts the count
      setv(0, 15'h7FFF, 11'h7FF, 1'b0);
      setv(1, 15'h6881, 11'h001, 1'b0);
      run_batch(2, 0, 0, 0, 0);

      // five errors: 8-bit counter reaches 5, 2-bit counter saturates at 3
      setv(0, 15'h1000, 11'h000, 1'b1);
      setv(1, 15'h4000, 11'h000, 1'b1);
      setv(2, 15'h6880, 11'h001, 1'b1);
      setv(3, 15'h7F7F, 11'h7FF, 1'b1);
      setv(4, 15'h0400, 11'h000, 1'b1);
      run_batch(5, 0, 0, 5, 3);

      // asynchronous reset mid-batch with words buffered
      vc[0] = 15'h1000; vc[1] = 15'h4000; vc[2] = 15'h0000;
      out_ready = 1'b0;
      in_last   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_code  = vc[i];
         #3;
         chk("mid_accept", in_ready, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_cnt", err_cnt, 2);
      chk("mid_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_cnt", err_cnt, 0);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_cnt2", err_cnt2, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_post_ready", in_ready, 1);
      chk("mid_post_valid", out_valid, 0);

      setv(0, 15'h7000, 11'h400, 1'b0);
      setv(1, 15'h0400, 11'h000, 1'b1);
      run_batch(2, 0, 0, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
